// File: rtl/zero_len_seq_gen.sv
// zero_len_seq_gen
//   Produces a/b/c traffic of the shape  a ##1 b[*N] ##1 c  with 0 <= N <= MAX_REP.
//   N = 0 yields a ##1 c (zero-length b repetition).
//   Optional responder (compile-time macro ZLSEQ_ACK_EN): answers req with ack
//   ACK_DLY cycles later, or combinationally when ACK_DLY = 0.
//   Reset is synchronous, active-low, and aborts any pattern in flight.
module zero_len_seq_gen #(
  parameter int CNT_W   = 4,
  parameter int MAX_REP = 8,
  parameter int ACK_DLY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             rep_clamped
`ifdef ZLSEQ_ACK_EN
  ,
  input  logic             req,
  output logic             ack
`endif
);

  // Elaboration-time guard: the counter must hold MAX_REP without wrapping.
  if ((MAX_REP < 0) || (ACK_DLY < 0) || (MAX_REP >= (32'sd1 <<< CNT_W))) begin : g_bad_params
    $error("zero_len_seq_gen: MAX_REP must fit in CNT_W bits and ACK_DLY must be >= 0");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_A    = 2'd1,
    ST_B    = 2'd2,
    ST_C    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_N    = CNT_W'(MAX_REP);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] n_lat;      // clamped N of the pattern in progress
  logic [CNT_W-1:0] cnt;        // remaining b cycles, loaded in A
  logic             accept;     // start taken this cycle (IDLE or C)
  logic             over;       // requested N exceeds MAX_REP
  logic [CNT_W-1:0] n_clamp;    // min(rep_cnt, MAX_REP)
  logic             a_d;
  logic             b_d;
  logic             c_d;
  logic             busy_d;
  logic             done_d;

  // Acceptance and clamping of an incoming request.
  always_comb begin
    over    = 1'b0;
    n_clamp = rep_cnt;
    accept  = 1'b0;
    if (rep_cnt > MAX_N) begin
      over    = 1'b1;
      n_clamp = MAX_N;
    end else begin
      over    = 1'b0;
      n_clamp = rep_cnt;
    end
    if (start && ((state == ST_IDLE) || (state == ST_C))) begin
      accept = 1'b1;
    end else begin
      accept = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; start in A or B is deliberately dropped, not queued.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_A;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_A: begin
        if (n_lat == CNT_ZERO) begin
          next_state = ST_C;
        end else begin
          next_state = ST_B;
        end
      end
      ST_B: begin
        // cnt holds N on the first B cycle, so leaving at 1 gives exactly N cycles.
        if (cnt <= CNT_ONE) begin
          next_state = ST_C;
        end else begin
          next_state = ST_B;
        end
      end
      ST_C: begin
        if (start) begin
          next_state = ST_A;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Latched N, repetition counter and sticky clamp flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_lat       <= CNT_ZERO;
      cnt         <= CNT_ZERO;
      rep_clamped <= 1'b0;
    end else begin
      if (accept) begin
        n_lat <= n_clamp;
        if (over) begin
          rep_clamped <= 1'b1;
        end
      end
      if (state == ST_A) begin
        cnt <= n_lat;
      end else if ((state == ST_B) && (cnt != CNT_ZERO)) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  // FSM output decode from the upcoming state, so the flops below present it in that state.
  always_comb begin
    a_d    = 1'b0;
    b_d    = 1'b0;
    c_d    = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (next_state)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_A: begin
        a_d    = 1'b1;
        busy_d = 1'b1;
      end
      ST_B: begin
        b_d    = 1'b1;
        busy_d = 1'b1;
      end
      ST_C: begin
        c_d    = 1'b1;
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset drops everything, so an aborted pattern never shows c or done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a    <= 1'b0;
      b    <= 1'b0;
      c    <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      a    <= a_d;
      b    <= b_d;
      c    <= c_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

`ifdef ZLSEQ_ACK_EN
  if (ACK_DLY == 0) begin : g_ack_comb
    // Same-cycle acknowledge, masked while reset is asserted.
    assign ack = req & rst_n;
  end else begin : g_ack_dly
    localparam int            DW       = $clog2(ACK_DLY + 1);
    localparam logic [DW-1:0] DLY_LOAD = DW'(ACK_DLY - 1);
    localparam logic [DW-1:0] DLY_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] DLY_ONE  = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] dly;     // cycles left before the ack edge; zero means idle
    logic          arm;
    logic          ack_d;

    // A req only arms the responder while no countdown is pending.
    always_comb begin
      arm   = 1'b0;
      ack_d = 1'b0;
      if (req && (dly == DLY_ZERO)) begin
        arm = 1'b1;
      end else begin
        arm = 1'b0;
      end
      if (arm && (DLY_LOAD == DLY_ZERO)) begin
        ack_d = 1'b1;
      end else if (dly == DLY_ONE) begin
        ack_d = 1'b1;
      end else begin
        ack_d = 1'b0;
      end
    end

    // Countdown and registered ack pulse, independent of the pattern FSM.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dly <= DLY_ZERO;
        ack <= 1'b0;
      end else begin
        ack <= ack_d;
        if (arm) begin
          dly <= DLY_LOAD;
        end else if (dly != DLY_ZERO) begin
          dly <= dly - DLY_ONE;
        end
      end
    end
  end
`else
  // Responder not built: no req/ack ports and no responder logic.
`endif

endmodule

// File: tb/tb_zero_len_seq_gen.sv
// Self-checking bench for zero_len_seq_gen. The reference model expands each
// accepted request into a queue of per-cycle expectations (a, N x b, c).
module tb_zero_len_seq_gen;

  localparam int CNT_W   = 4;
  localparam int MAX_REP = 8;
  localparam int ACK_DLY = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] rep_cnt;
  logic             a, b, c, busy, done, rep_clamped;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: 0 idle, 1 a, 2 b, 3 c
  int q[$];
  int cur     = 0;
  bit m_clamp = 1'b0;
  int cyc     = 0;

`ifdef ZLSEQ_ACK_EN
  logic req;
  logic ack;
  logic ack0;
  logic a0, b0, c0, busy0, done0, clamp0;
  int   due = -1;
`endif

  always #5 clk = ~clk;

  zero_len_seq_gen #(.CNT_W(CNT_W), .MAX_REP(MAX_REP), .ACK_DLY(ACK_DLY)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rep_cnt(rep_cnt),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .rep_clamped(rep_clamped)
`ifdef ZLSEQ_ACK_EN
    , .req(req), .ack(ack)
`endif
  );

`ifdef ZLSEQ_ACK_EN
  zero_len_seq_gen #(.CNT_W(CNT_W), .MAX_REP(MAX_REP), .ACK_DLY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .rep_cnt(rep_cnt),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .rep_clamped(clamp0),
    .req(req), .ack(ack0)
  );
`endif

  function automatic logic [5:0] exp_vec();
    return {cur == 1, cur == 2, cur == 3, cur != 0, cur == 3, m_clamp};
  endfunction

  // Advance one clock edge with the current inputs and update the model.
  task automatic tick();
    int n;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      cur     = 0;
      m_clamp = 1'b0;
`ifdef ZLSEQ_ACK_EN
      due = -1;
`endif
    end else begin
      if (start && (cur == 0 || cur == 3)) begin
        n = (int'(rep_cnt) > MAX_REP) ? MAX_REP : int'(rep_cnt);
        if (int'(rep_cnt) > MAX_REP) m_clamp = 1'b1;
        q.push_back(1);
        repeat (n) q.push_back(2);
        q.push_back(3);
      end
`ifdef ZLSEQ_ACK_EN
      if (req && !(cyc < due)) due = cyc + ACK_DLY;
`endif
    end
    cur = (q.size() > 0) ? q.pop_front() : 0;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; rep_cnt = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({a, b, c, busy, done, rep_clamped} !== 6'b000000) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%b want=%b", cyc, {a, b, c, busy, done, rep_clamped}, 6'b000000);
      end
    end
    start = 1'b0; rst_n = 1'b1;
    tick();
    n_checks++;
    if ({a, b, c, busy, done, rep_clamped} !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release got=%b want=%b", {a, b, c, busy, done, rep_clamped}, exp_vec());
    end
  endtask

  task automatic test_zero_len();
    int bcnt = 0;
    start = 1'b1; rep_cnt = 4'd0;
    tick();
    start = 1'b0; rep_cnt = 4'd7;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({a, b, c, busy, done, rep_clamped} !== exp_vec()) begin
        n_fail++;
        $display("FAIL zero_len cyc=%0d got=%b want=%b", cyc, {a, b, c, busy, done, rep_clamped}, exp_vec());
      end
      if (b) bcnt++;
      tick();
    end
    n_checks++;
    if (bcnt != 0) begin
      n_fail++;
      $display("FAIL zero_len_bcount got=%0d want=0", bcnt);
    end
  endtask

  task automatic test_rep_lengths();
    int reps[4] = '{2, MAX_REP, 1, 12};
    int bcnt;
    int want;
    for (int k = 0; k < 4; k++) begin
      bcnt = 0;
      want = (reps[k] > MAX_REP) ? MAX_REP : reps[k];
      start = 1'b1; rep_cnt = CNT_W'(reps[k]);
      tick();
      start = 1'b0;
      for (int i = 0; i < MAX_REP + 4; i++) begin
        n_checks++;
        if ({a, b, c, busy, done, rep_clamped} !== exp_vec()) begin
          n_fail++;
          $display("FAIL rep_len n=%0d cyc=%0d got=%b want=%b", reps[k], cyc, {a, b, c, busy, done, rep_clamped}, exp_vec());
        end
        if (b) bcnt++;
        tick();
      end
      n_checks++;
      if (bcnt != want) begin
        n_fail++;
        $display("FAIL rep_len_bcount n=%0d got=%0d want=%0d", reps[k], bcnt, want);
      end
    end
    n_checks++;
    if (rep_clamped !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_sticky got=%b want=1", rep_clamped);
    end
  endtask

  task automatic test_back_to_back();
    int bcnt = 0;
    start = 1'b1; rep_cnt = 4'd1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if ({a, b, c, busy, done, rep_clamped} !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d got=%b want=%b", cyc, {a, b, c, busy, done, rep_clamped}, exp_vec());
      end
    end
    start = 1'b0;
    repeat (3) tick();
    // fresh N=3 pattern, then a start pulse during B must be ignored
    start = 1'b1; rep_cnt = 4'd3;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; rep_cnt = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({a, b, c, busy, done, rep_clamped} !== exp_vec()) begin
        n_fail++;
        $display("FAIL start_in_b cyc=%0d got=%b want=%b", cyc, {a, b, c, busy, done, rep_clamped}, exp_vec());
      end
      if (b) bcnt++;
      tick();
    end
    n_checks++;
    if (bcnt != 2) begin
      n_fail++;
      $display("FAIL start_in_b_bcount got=%0d want=2", bcnt);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; rep_cnt = 4'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({a, b, c, busy, done, rep_clamped} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_mid got=%b want=%b", {a, b, c, busy, done, rep_clamped}, 6'b000000);
    end
    start = 1'b1; rep_cnt = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({a, b, c, busy, done, rep_clamped} !== exp_vec()) begin
        n_fail++;
        $display("FAIL restart cyc=%0d got=%b want=%b", cyc, {a, b, c, busy, done, rep_clamped}, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start   = ($urandom_range(0, 2) == 0);
      rep_cnt = CNT_W'($urandom_range(0, 15));
      rst_n   = ($urandom_range(0, 63) != 0);
      tick();
      n_checks++;
      if ({a, b, c, busy, done, rep_clamped} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%b want=%b", cyc, {a, b, c, busy, done, rep_clamped}, exp_vec());
      end
    end
    rst_n = 1'b1; start = 1'b0;
  endtask

`ifdef ZLSEQ_ACK_EN
  task automatic test_ack();
    logic pat[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8 + 60; i++) begin
      req = (i < 8) ? pat[i] : ($urandom_range(0, 2) == 0);
      #1;
      n_checks++;
      if (ack0 !== (req & rst_n)) begin
        n_fail++;
        $display("FAIL ack_comb cyc=%0d got=%b want=%b", cyc, ack0, req & rst_n);
      end
      tick();
      n_checks++;
      if (ack !== (due == cyc)) begin
        n_fail++;
        $display("FAIL ack_dly cyc=%0d got=%b want=%b", cyc, ack, due == cyc);
      end
    end
    req = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; rep_cnt = 4'd0;
`ifdef ZLSEQ_ACK_EN
    req = 1'b0;
`endif
    test_reset();
    test_zero_len();
    test_rep_lengths();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef ZLSEQ_ACK_EN
    test_ack();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
